// File: rtl/csr_irq_ctrl.sv
`default_nettype none
// ============================================================================
// csr_irq_ctrl - MIP/MIE state, interrupt select and WFI stall FSM.
// Optional IRQ_SYNC_EN adds a two-flop input synchroniser. Rev 1.0
// ============================================================================
module csr_irq_ctrl #(
  parameter int XLEN        = 64,
  parameter int S_SUPPORTED = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            CSRMWriteM,
  input  logic [11:0]     CSRAdrM,
  input  logic [XLEN-1:0] CSRWriteValM,
  input  logic            MExtInt,
  input  logic            SExtInt,
  input  logic            MTimerInt,
  input  logic            MSwInt,
  input  logic [1:0]      PrivilegeModeM,
  input  logic            STATUS_MIE,
  input  logic            STATUS_SIE,
  input  logic [11:0]     MIDELEG_REGW,
  input  logic            WFIM,
  output logic [11:0]     MIP_REGW,
  output logic [11:0]     MIE_REGW,
  output logic            InterruptM,
  output logic [3:0]      IntCauseM,
  output logic            WFIStallM
);

  localparam logic        S_EN     = (S_SUPPORTED != 0);
  localparam logic [11:0] MIE_MASK = S_EN ? 12'hAAA : 12'h888;
  localparam logic [11:0] MIP_MASK = S_EN ? 12'h222 : 12'h000;
  localparam logic [11:0] ADR_MIE  = 12'h304;
  localparam logic [11:0] ADR_MIP  = 12'h344;
  localparam logic [1:0]  PRIV_M   = 2'b11;
  localparam logic [1:0]  PRIV_S   = 2'b01;
  localparam logic [1:0]  PRIV_U   = 2'b00;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } wfi_state_t;

  logic [11:0] w_wdata;
  logic        w_unused_wdata;
  logic [3:0]  w_irq_in;
  logic [3:0]  r_irq_s;
  logic [11:0] r_mie;
  logic        r_ssip, r_stip, r_seip;
  logic [11:0] w_mip;
  logic [11:0] w_pend;
  logic [11:0] w_en;
  logic        w_m_on, w_s_on;
  wfi_state_t  r_state, w_state_nxt;

  assign w_wdata        = CSRWriteValM[11:0];
  assign w_unused_wdata = ^CSRWriteValM[XLEN-1:12];
  // Packed as {MEI, SEI, MTI, MSI}
  assign w_irq_in       = {MExtInt, SExtInt, MTimerInt, MSwInt};

`ifdef IRQ_SYNC_EN
  logic [3:0] r_irq_meta;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_meta <= '0;
      r_irq_s    <= '0;
    end else begin
      r_irq_meta <= w_irq_in;
      r_irq_s    <= r_irq_meta;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq_s <= '0;
    else       r_irq_s <= w_irq_in;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mie  <= '0;
      r_ssip <= 1'b0;
      r_stip <= 1'b0;
      r_seip <= 1'b0;
    end else if (CSRMWriteM) begin
      if (CSRAdrM == ADR_MIE) r_mie <= w_wdata & MIE_MASK;
      if (CSRAdrM == ADR_MIP) begin
        r_ssip <= w_wdata[1] & MIP_MASK[1];
        r_stip <= w_wdata[5] & MIP_MASK[5];
        r_seip <= w_wdata[9] & MIP_MASK[9];
      end
    end
  end

  always_comb begin
    w_mip     = '0;
    w_mip[11] = r_irq_s[3];
    // External S line and software SEIP are OR-ed, so clearing one never hides the other
    w_mip[9]  = (r_irq_s[2] & S_EN) | r_seip;
    w_mip[7]  = r_irq_s[1];
    w_mip[5]  = r_stip;
    w_mip[3]  = r_irq_s[0];
    w_mip[1]  = r_ssip;
  end

  assign MIP_REGW = w_mip;
  assign MIE_REGW = r_mie;
  assign w_pend   = w_mip & r_mie;

  assign w_m_on = (PrivilegeModeM != PRIV_M) | STATUS_MIE;
  assign w_s_on = (PrivilegeModeM == PRIV_U) | ((PrivilegeModeM == PRIV_S) & STATUS_SIE);
  assign w_en   = w_pend & ((~MIDELEG_REGW & {12{w_m_on}}) | (MIDELEG_REGW & {12{w_s_on}}));

  assign InterruptM = |w_en;

  always_comb begin
    IntCauseM = 4'd0;
    if      (w_en[11]) IntCauseM = 4'd11;
    else if (w_en[3])  IntCauseM = 4'd3;
    else if (w_en[7])  IntCauseM = 4'd7;
    else if (w_en[9])  IntCauseM = 4'd9;
    else if (w_en[1])  IntCauseM = 4'd1;
    else if (w_en[5])  IntCauseM = 4'd5;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Wake uses raw pending&enable, ignoring global enables and delegation
  always_comb begin
    w_state_nxt = r_state;
    WFIStallM   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (WFIM && (w_pend == 12'd0)) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        WFIStallM = 1'b1;
        if (|w_pend) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_irq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_csr_irq_ctrl - directed stimulus with a queued scoreboard and monitor.
// Rev 1.0
// ============================================================================
module tb_csr_irq_ctrl;
  localparam int XLEN = 64;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [4:0] S_MIP = 5'b00001;
  localparam logic [4:0] S_MIE = 5'b00010;
  localparam logic [4:0] S_INT = 5'b00100;
  localparam logic [4:0] S_CAU = 5'b01000;
  localparam logic [4:0] S_STL = 5'b10000;
  localparam logic [4:0] S_ALL = 5'b11111;

  logic            clk = 1'b0;
  logic            reset;
  logic            CSRMWriteM;
  logic [11:0]     CSRAdrM;
  logic [XLEN-1:0] CSRWriteValM;
  logic            MExtInt, SExtInt, MTimerInt, MSwInt;
  logic [1:0]      PrivilegeModeM;
  logic            STATUS_MIE, STATUS_SIE;
  logic [11:0]     MIDELEG_REGW;
  logic            WFIM;
  logic [11:0]     MIP_REGW, MIE_REGW;
  logic            InterruptM;
  logic [3:0]      IntCauseM;
  logic            WFIStallM;

  typedef struct {
    string       name;
    logic [4:0]  sel;
    logic [11:0] mip;
    logic [11:0] mie;
    logic        intr;
    logic [3:0]  cause;
    logic        stall;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  csr_irq_ctrl #(.XLEN(XLEN), .S_SUPPORTED(1)) dut (
    .clk(clk), .reset(reset), .CSRMWriteM(CSRMWriteM), .CSRAdrM(CSRAdrM),
    .CSRWriteValM(CSRWriteValM), .MExtInt(MExtInt), .SExtInt(SExtInt),
    .MTimerInt(MTimerInt), .MSwInt(MSwInt), .PrivilegeModeM(PrivilegeModeM),
    .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE), .MIDELEG_REGW(MIDELEG_REGW),
    .WFIM(WFIM), .MIP_REGW(MIP_REGW), .MIE_REGW(MIE_REGW), .InterruptM(InterruptM),
    .IntCauseM(IntCauseM), .WFIStallM(WFIStallM)
  );

  always #5 clk = ~clk;

  // Monitor: every expectation queued before a falling edge is checked there
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.sel[0]) begin
        n_cmp++;
        if (MIP_REGW !== mon_e.mip) begin
          n_bad++;
          $display("FAIL %s MIP_REGW got %h want %h", mon_e.name, MIP_REGW, mon_e.mip);
        end
      end
      if (mon_e.sel[1]) begin
        n_cmp++;
        if (MIE_REGW !== mon_e.mie) begin
          n_bad++;
          $display("FAIL %s MIE_REGW got %h want %h", mon_e.name, MIE_REGW, mon_e.mie);
        end
      end
      if (mon_e.sel[2]) begin
        n_cmp++;
        if (InterruptM !== mon_e.intr) begin
          n_bad++;
          $display("FAIL %s InterruptM got %b want %b", mon_e.name, InterruptM, mon_e.intr);
        end
      end
      if (mon_e.sel[3]) begin
        n_cmp++;
        if (IntCauseM !== mon_e.cause) begin
          n_bad++;
          $display("FAIL %s IntCauseM got %0d want %0d", mon_e.name, IntCauseM, mon_e.cause);
        end
      end
      if (mon_e.sel[4]) begin
        n_cmp++;
        if (WFIStallM !== mon_e.stall) begin
          n_bad++;
          $display("FAIL %s WFIStallM got %b want %b", mon_e.name, WFIStallM, mon_e.stall);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] sel,
                     input logic [11:0] mip, input logic [11:0] mie,
                     input logic intr, input logic [3:0] cause, input logic stall);
    exp_t e;
    e.name = name; e.sel = sel; e.mip = mip; e.mie = mie;
    e.intr = intr; e.cause = cause; e.stall = stall;
    sb_q.push_back(e);
    tick();
  endtask

  task automatic csr_write(input logic [11:0] adr, input logic [XLEN-1:0] val);
    CSRMWriteM   = 1'b1;
    CSRAdrM      = adr;
    CSRWriteValM = val;
    tick();
    CSRMWriteM   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; CSRMWriteM = 1'b0; CSRAdrM = '0; CSRWriteValM = '0;
    MExtInt = 1'b0; SExtInt = 1'b0; MTimerInt = 1'b0; MSwInt = 1'b0;
    PrivilegeModeM = 2'b11; STATUS_MIE = 1'b0; STATUS_SIE = 1'b0;
    MIDELEG_REGW = '0; WFIM = 1'b0;
    tick();
    chk("reset", S_ALL, 12'h000, 12'h000, 1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    tick();

    // CSR write masks and address decode
    csr_write(12'h304, 64'hFFF);
    chk("mie_mask", S_MIE | S_MIP | S_INT, 12'h000, 12'hAAA, 1'b0, 4'd0, 1'b0);
    csr_write(12'h344, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mip_mask", S_MIP | S_INT, 12'h222, 12'h0, 1'b0, 4'd0, 1'b0);
    csr_write(12'h300, 64'h0);
    chk("other_adr", S_MIP | S_MIE, 12'h222, 12'hAAA, 1'b0, 4'd0, 1'b0);
    csr_write(12'h344, 64'h0);
    csr_write(12'h304, 64'h080);
    chk("mie_080", S_MIE | S_MIP, 12'h000, 12'h080, 1'b0, 4'd0, 1'b0);

    // Machine timer: latency then select
    MTimerInt = 1'b1; STATUS_MIE = 1'b1;
    chk("mti_lat0", S_MIP, 12'h000, 12'h0, 1'b0, 4'd0, 1'b0);
    chk("mti_lat1", S_MIP, (LAT == 1) ? 12'h080 : 12'h000, 12'h0, 1'b0, 4'd0, 1'b0);
    chk("mti_take", S_MIP | S_INT | S_CAU, 12'h080, 12'h0, 1'b1, 4'd7, 1'b0);
    STATUS_MIE = 1'b0;
    chk("mti_mie0", S_INT | S_CAU, 12'h0, 12'h0, 1'b0, 4'd0, 1'b0);

    // MSI beats MTI in U mode
    MSwInt = 1'b1; PrivilegeModeM = 2'b00;
    csr_write(12'h304, 64'h088);
    tick();
    chk("msi_prio", S_MIP | S_INT | S_CAU, 12'h088, 12'h0, 1'b1, 4'd3, 1'b0);

    // Delegated software pending bits in S mode
    MSwInt = 1'b0; MTimerInt = 1'b0;
    csr_write(12'h304, 64'h222);
    tick();
    MIDELEG_REGW = 12'h222;
    csr_write(12'h344, 64'h222);
    PrivilegeModeM = 2'b01; STATUS_SIE = 1'b1;
    chk("deleg_s_sie1", S_MIP | S_INT | S_CAU, 12'h222, 12'h0, 1'b1, 4'd9, 1'b0);
    STATUS_SIE = 1'b0;
    chk("deleg_s_sie0", S_INT | S_CAU, 12'h0, 12'h0, 1'b0, 4'd0, 1'b0);
    PrivilegeModeM = 2'b11; STATUS_SIE = 1'b1; STATUS_MIE = 1'b1;
    chk("deleg_in_m", S_INT, 12'h0, 12'h0, 1'b0, 4'd0, 1'b0);
    STATUS_MIE = 1'b0; STATUS_SIE = 1'b0;

    // SEI line keeps bit 9 set after software clear
    SExtInt = 1'b1;
    tick(); tick();
    csr_write(12'h344, 64'h0);
    chk("sei_hold", S_MIP, 12'h200, 12'h0, 1'b0, 4'd0, 1'b0);
    SExtInt = 1'b0;
    tick(); tick();
    chk("sei_clear", S_MIP, 12'h000, 12'h0, 1'b0, 4'd0, 1'b0);

    // WFI enter and wake on MEI with globals off
    csr_write(12'h304, 64'h800);
    MIDELEG_REGW = 12'h000;
    WFIM = 1'b1; tick(); WFIM = 1'b0;
    chk("wfi_enter", S_STL | S_INT, 12'h0, 12'h0, 1'b0, 4'd0, 1'b1);
    chk("wfi_hold", S_STL, 12'h0, 12'h0, 1'b0, 4'd0, 1'b1);
    MExtInt = 1'b1;
    chk("wfi_pre", S_STL | S_INT, 12'h0, 12'h0, 1'b0, 4'd0, 1'b1);
    chk("wfi_edge_n", S_STL, 12'h0, 12'h0, 1'b0, 4'd0, 1'b1);
    chk("wfi_wake_a", S_STL | S_MIP | S_INT, 12'h800, 12'h0, 1'b0, 4'd0, (LAT == 2));
    chk("wfi_wake_b", S_STL | S_INT | S_CAU, 12'h0, 12'h0, 1'b0, 4'd0, 1'b0);

    // WFI with pending work does not stall
    WFIM = 1'b1; tick(); WFIM = 1'b0;
    chk("wfi_busy", S_STL, 12'h0, 12'h0, 1'b0, 4'd0, 1'b0);

    // Same-cycle MIE write and WFI sees the old enable vector
    csr_write(12'h304, 64'h0);
    CSRMWriteM = 1'b1; CSRAdrM = 12'h304; CSRWriteValM = 64'h800; WFIM = 1'b1;
    tick();
    CSRMWriteM = 1'b0; WFIM = 1'b0;
    chk("wfi_prewrite", S_STL | S_MIE, 12'h0, 12'h800, 1'b0, 4'd0, 1'b1);
    chk("wfi_prewrite_wake", S_STL, 12'h0, 12'h0, 1'b0, 4'd0, 1'b0);

    // Asynchronous reset out of WAIT
    MExtInt = 1'b0;
    tick(); tick();
    csr_write(12'h304, 64'h088);
    WFIM = 1'b1; tick(); WFIM = 1'b0;
    chk("wfi_enter2", S_STL | S_MIE, 12'h0, 12'h088, 1'b0, 4'd0, 1'b1);
    reset = 1'b1;
    chk("rst_async", S_ALL, 12'h000, 12'h000, 1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    chk("rst_after", S_MIE | S_STL, 12'h0, 12'h000, 1'b0, 4'd0, 1'b0);

    tick();
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain queue left %0d want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
